// File: rtl/div_pkg.sv
// Shared types and constants for the pipelined restoring divider output stage.
package div_pkg;

    localparam int DIV_N  = 16;
    localparam int DIV_M  = 10;
    localparam int DIV_TW = 4;

    function automatic int qw_of(input int n, input int m);
        return n - m + 1;
    endfunction

    localparam int DIV_QW = qw_of(DIV_N, DIV_M);

    typedef struct packed {
        logic              valid;
        logic [DIV_TW-1:0] tag;
        logic              neg_q;
        logic              neg_r;
        logic              dbz;
    } div_sb_t;

    typedef struct packed {
        logic [DIV_QW-1:0] quotient;
        logic [DIV_M-1:0]  remainder;
        logic [DIV_TW-1:0] tag;
        logic              dbz;
    } div_entry_t;

    localparam logic [DIV_QW-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_result_collector_if.sv
// Request, divider-tail and result ports of the divider output stage.
interface div_result_collector_if
    import div_pkg::*;
#(
    parameter int QW = DIV_QW,
    parameter int M  = DIV_M,
    parameter int TW = DIV_TW
);
    logic          in_valid;
    logic [TW-1:0] in_tag;
    logic          in_neg_q;
    logic          in_neg_r;
    logic          in_dbz;
    logic          issue_ok;
    logic          pipe_rdy;
    logic [QW-1:0] pipe_quotient;
    logic [M-1:0]  pipe_remainder;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] out_quotient;
    logic [M-1:0]  out_remainder;
    logic [TW-1:0] out_tag;
    logic          out_dbz;
    logic          align_err;

    modport master (
        output in_valid, in_tag, in_neg_q, in_neg_r, in_dbz,
        output pipe_rdy, pipe_quotient, pipe_remainder, out_ready,
        input  issue_ok, out_valid, out_quotient, out_remainder, out_tag, out_dbz, align_err
    );

    modport slave (
        input  in_valid, in_tag, in_neg_q, in_neg_r, in_dbz,
        input  pipe_rdy, pipe_quotient, pipe_remainder, out_ready,
        output issue_ok, out_valid, out_quotient, out_remainder, out_tag, out_dbz, align_err
    );
endinterface

// File: rtl/div_result_fifo.sv
// Shift-style FWFT result FIFO; entry 0 is the registered head driving the outputs.
module div_result_fifo
    import div_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  div_entry_t                   wdata,
    input  logic                         pop,
    output div_entry_t                   head,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);

    div_entry_t    mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [CW-1:0] wr_idx;
    logic          pop_ok;

    assign pop_ok = pop & (cnt != '0);
    // When popping, the whole array shifts down, so the new entry lands one slot lower.
    assign wr_idx = pop_ok ? cnt - 1'b1 : cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pop_ok && i < DEPTH-1) mem[i] <= mem[i+1];
                if (push && wr_idx == CW'(i)) mem[i] <= wdata;
            end
            cnt <= cnt + CW'(push) - CW'(pop_ok);
        end
    end

    assign head       = mem[0];
    assign head_valid = (cnt != '0);
    assign count      = cnt;

endmodule

// File: rtl/div_result_collector.sv
// Divider output stage: sideband delay line, sign/dbz correction, credit-based FIFO.
// Build option DIV_COLLECT_SIGN_EN enables quotient/remainder sign correction.
module div_result_collector
    import div_pkg::*;
#(
    parameter int N     = DIV_N,
    parameter int M     = DIV_M,
    parameter int LAT   = N - M + 1,
    parameter int DEPTH = 4,
    parameter int TW    = DIV_TW
) (
    input  logic                  clk,
    input  logic                  rstn,
    div_result_collector_if.slave bus
);
    localparam int QW = qw_of(N, M);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    div_sb_t       dl [LAT];
    div_sb_t       sb_in;
    div_sb_t       sb_tail;
    logic          accept;
    logic          sb_v;
    logic          pop;
    logic          head_valid;
    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic [QW-1:0] q_corr;
    logic [M-1:0]  r_corr;
    logic [TW-1:0] tail_tag;
    div_entry_t    wr_entry;
    div_entry_t    head;
    logic          align_err_q;

    assign accept = bus.in_valid & bus.issue_ok;

    always_comb begin
        sb_in       = '0;
        sb_in.valid = accept;
        sb_in.tag   = bus.in_tag;
        sb_in.dbz   = bus.in_dbz;
`ifdef DIV_COLLECT_SIGN_EN
        sb_in.neg_q = bus.in_neg_q;
        sb_in.neg_r = bus.in_neg_r;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) dl[i] <= '0;
        end else begin
            dl[0] <= sb_in;
            for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
        end
    end

    assign sb_tail  = dl[LAT-1];
    assign sb_v     = sb_tail.valid;
    assign tail_tag = sb_tail.tag;

    always_comb begin
        q_corr = bus.pipe_quotient;
        r_corr = bus.pipe_remainder;
`ifdef DIV_COLLECT_SIGN_EN
        if (sb_tail.neg_q) q_corr = -bus.pipe_quotient;
        if (sb_tail.neg_r) r_corr = -bus.pipe_remainder;
`endif
        // Divide-by-zero: saturate the quotient, pass the remainder through unsigned.
        if (sb_tail.dbz) begin
            q_corr = DBZ_QUOTIENT;
            r_corr = bus.pipe_remainder;
        end
    end

    always_comb begin
        wr_entry           = '0;
        wr_entry.quotient  = q_corr;
        wr_entry.remainder = r_corr;
        wr_entry.tag       = tail_tag;
        wr_entry.dbz       = sb_tail.dbz;
    end

    // A slot stays reserved from issue until it is popped; sb_v only moves it into the FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= '0;
        end else begin
            case ({accept, sb_v})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign credit_used  = {1'b0, fifo_count} + {1'b0, inflight};
    assign bus.issue_ok = (credit_used < DEPTH_W);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                      align_err_q <= 1'b0;
        else if (bus.pipe_rdy != sb_v)  align_err_q <= 1'b1;
    end

    assign bus.align_err = align_err_q;
    assign pop           = head_valid & bus.out_ready;

    div_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (sb_v),
        .wdata      (wr_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign bus.out_valid     = head_valid;
    assign bus.out_quotient  = head.quotient;
    assign bus.out_remainder = head.remainder;
    assign bus.out_tag       = head.tag;
    assign bus.out_dbz       = head.dbz;

endmodule

// File: tb/tb_div_result_collector.sv
// Directed bench for div_result_collector with a behavioural LAT-deep divider tail.
module tb_div_result_collector;
    localparam int LAT = 7;

`ifdef DIV_COLLECT_SIGN_EN
    localparam logic [6:0] EXP_NEG_Q = 7'h7B;
    localparam logic [9:0] EXP_NEG_R = 10'h3FD;
`else
    localparam logic [6:0] EXP_NEG_Q = 7'h05;
    localparam logic [9:0] EXP_NEG_R = 10'h003;
`endif

    logic clk;
    logic rstn;
    logic force_rdy;
    logic [6:0] stim_q;
    logic [9:0] stim_r;
    int n_assert;
    int n_fail;

    div_result_collector_if bus ();

    div_result_collector dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider tail model: accepted requests come out LAT cycles later, idle cells read zero.
    logic [LAT-1:0] sh_v;
    logic [6:0]     sh_q [LAT];
    logic [9:0]     sh_r [LAT];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                sh_q[i] <= '0;
                sh_r[i] <= '0;
            end
        end else begin
            sh_v    <= {sh_v[LAT-2:0], bus.in_valid & bus.issue_ok};
            sh_q[0] <= (bus.in_valid & bus.issue_ok) ? stim_q : 7'h00;
            sh_r[0] <= (bus.in_valid & bus.issue_ok) ? stim_r : 10'h000;
            for (int i = 1; i < LAT; i++) begin
                sh_q[i] <= sh_q[i-1];
                sh_r[i] <= sh_r[i-1];
            end
        end
    end

    assign bus.pipe_rdy       = sh_v[LAT-1] | force_rdy;
    assign bus.pipe_quotient  = sh_q[LAT-1];
    assign bus.pipe_remainder = sh_r[LAT-1];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] tag, input logic nq, input logic nr,
                         input logic dbz, input logic [6:0] q, input logic [9:0] r);
        bus.in_valid = 1'b1;
        bus.in_tag   = tag;
        bus.in_neg_q = nq;
        bus.in_neg_r = nr;
        bus.in_dbz   = dbz;
        stim_q       = q;
        stim_r       = r;
        tick(1);
        bus.in_valid = 1'b0;
        bus.in_neg_q = 1'b0;
        bus.in_neg_r = 1'b0;
        bus.in_dbz   = 1'b0;
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rstn          = 1'b0;
        force_rdy     = 1'b0;
        stim_q        = '0;
        stim_r        = '0;
        bus.in_valid  = 1'b0;
        bus.in_tag    = '0;
        bus.in_neg_q  = 1'b0;
        bus.in_neg_r  = 1'b0;
        bus.in_dbz    = 1'b0;
        bus.out_ready = 1'b0;

        tick(2);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_q",     32'(bus.out_quotient), 32'd0);
        chk("rst_out_r",     32'(bus.out_remainder), 32'd0);
        chk("rst_out_tag",   32'(bus.out_tag), 32'd0);
        chk("rst_out_dbz",   32'(bus.out_dbz), 32'd0);
        chk("rst_align_err", 32'(bus.align_err), 32'd0);
        chk("rst_issue_ok",  32'(bus.issue_ok), 32'd1);
        rstn = 1'b1;
        tick(1);

        // Single request: visible LAT+1 cycles after issue, not before.
        issue(4'd3, 1'b0, 1'b0, 1'b0, 7'h25, 10'h011);
        tick(LAT-1);
        chk("single_early", 32'(bus.out_valid), 32'd0);
        tick(1);
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_q",     32'(bus.out_quotient), 32'h25);
        chk("single_r",     32'(bus.out_remainder), 32'h011);
        chk("single_tag",   32'(bus.out_tag), 32'd3);
        chk("single_dbz",   32'(bus.out_dbz), 32'd0);
        tick(2);
        chk("hold_q",       32'(bus.out_quotient), 32'h25);
        chk("hold_valid",   32'(bus.out_valid), 32'd1);
        pop_one();
        chk("single_drain", 32'(bus.out_valid), 32'd0);

        // Backpressure: only DEPTH requests are accepted while nothing drains.
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_tag   = 4'(i);
            stim_q       = 7'(8'h10 + i);
            stim_r       = 10'(12'h100 + i);
            tick(1);
            chk($sformatf("bp_issue_ok_%0d", i), 32'(bus.issue_ok), (i < 3) ? 32'd1 : 32'd0);
        end
        bus.in_valid = 1'b0;
        tick(10);
        chk("bp_full_issue_ok", 32'(bus.issue_ok), 32'd0);
        chk("bp_valid",         32'(bus.out_valid), 32'd1);
        chk("bp_tag0",          32'(bus.out_tag), 32'd0);
        chk("bp_q0",            32'(bus.out_quotient), 32'h10);
        bus.out_ready = 1'b1;
        tick(1);
        chk("bp_tag1",          32'(bus.out_tag), 32'd1);
        chk("bp_credit_back",   32'(bus.issue_ok), 32'd1);
        tick(1);
        chk("bp_tag2",          32'(bus.out_tag), 32'd2);
        tick(1);
        chk("bp_tag3",          32'(bus.out_tag), 32'd3);
        chk("bp_q3",            32'(bus.out_quotient), 32'h13);
        chk("bp_r3",            32'(bus.out_remainder), 32'h103);
        tick(1);
        chk("bp_empty",         32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Sign correction (values depend on whether the option is built in).
        issue(4'd5, 1'b1, 1'b1, 1'b0, 7'h05, 10'h003);
        tick(LAT);
        chk("sign_valid", 32'(bus.out_valid), 32'd1);
        chk("sign_q",     32'(bus.out_quotient), 32'(EXP_NEG_Q));
        chk("sign_r",     32'(bus.out_remainder), 32'(EXP_NEG_R));
        chk("sign_tag",   32'(bus.out_tag), 32'd5);
        pop_one();

        // Divide-by-zero overrides negation: all-ones quotient, raw remainder.
        issue(4'd7, 1'b1, 1'b1, 1'b1, 7'h00, 10'h02A);
        tick(LAT);
        chk("dbz_valid", 32'(bus.out_valid), 32'd1);
        chk("dbz_q",     32'(bus.out_quotient), 32'h7F);
        chk("dbz_r",     32'(bus.out_remainder), 32'h02A);
        chk("dbz_flag",  32'(bus.out_dbz), 32'd1);
        pop_one();
        chk("dbz_drain", 32'(bus.out_valid), 32'd0);

        // Misalignment: stray pipe_rdy with nothing in the delay line.
        force_rdy = 1'b1;
        tick(1);
        force_rdy = 1'b0;
        chk("mis_set",    32'(bus.align_err), 32'd1);
        chk("mis_nowr",   32'(bus.out_valid), 32'd0);
        tick(3);
        chk("mis_sticky", 32'(bus.align_err), 32'd1);
        chk("mis_nowr2",  32'(bus.out_valid), 32'd0);

        // Reset with three requests in flight.
        issue(4'd9, 1'b0, 1'b0, 1'b0, 7'h11, 10'h021);
        issue(4'd10, 1'b0, 1'b0, 1'b0, 7'h12, 10'h022);
        issue(4'd11, 1'b0, 1'b0, 1'b0, 7'h13, 10'h023);
        tick(2);
        chk("rmf_pre_issue_ok", 32'(bus.issue_ok), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rmf_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rmf_issue_ok",  32'(bus.issue_ok), 32'd1);
        chk("rmf_align_clr", 32'(bus.align_err), 32'd0);
        tick(1);
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk($sformatf("rmf_no_result_%0d", i), 32'(bus.out_valid), 32'd0);
        end
        chk("rmf_align_ok", 32'(bus.align_err), 32'd0);

        // Fresh request after reset, with maximum field values.
        issue(4'd6, 1'b0, 1'b0, 1'b0, 7'h7F, 10'h3FF);
        tick(LAT);
        chk("post_valid", 32'(bus.out_valid), 32'd1);
        chk("post_q",     32'(bus.out_quotient), 32'h7F);
        chk("post_r",     32'(bus.out_remainder), 32'h3FF);
        chk("post_tag",   32'(bus.out_tag), 32'd6);
        chk("post_dbz",   32'(bus.out_dbz), 32'd0);
        pop_one();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
